// File: rtl/ucode_pkg.sv
// Shared microcode constants and issue-FSM states, common to the opcode encoder and decoder.
package ucode_pkg;
    localparam int NUM_OPS = 16;
    localparam int OP_W    = $clog2(NUM_OPS);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/ucode_op_encoder_rr_pick.sv
// Round-robin picker: first set bit of vec at or above ptr, wrapping; combinational, no backpressure.
module rr_pick
    import ucode_pkg::*;
(
    input  logic [NUM_OPS-1:0] vec,
    input  logic [OP_W-1:0]    ptr,
    output logic               found,
    output logic [OP_W-1:0]    idx
);
    logic [NUM_OPS-1:0] rot;
    logic [OP_W-1:0]    off;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then add ptr back (wraps mod NUM_OPS).
    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            rot[i] = vec[OP_W'(i) + ptr];
        end
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = OP_W'(i);
            end
        end
    end

    assign idx = off + ptr;
endmodule

// File: rtl/ucode_op_encoder.sv
// Collects one-hot op requests, picks round-robin, encodes into a registered opcode/enable word.
// Request-to-valid latency 2 cycles; word held stable while cw_valid && !cw_ready.
module ucode_op_encoder
    import ucode_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_OPS-1:0] req_pulse,
    input  logic [NUM_OPS-1:0] pim_mask,
    input  logic               cw_ready,
    input  logic               clr_err,
    output logic               cw_valid,
    output logic [OP_W-1:0]    cw_opcode,
    output logic               cw_enable,
    output logic [NUM_OPS-1:0] gnt,
    output logic [NUM_OPS-1:0] pend_o,
    output logic               drop_err
);
    state_t             state_q;
    logic [NUM_OPS-1:0] pend_q, pend_d;
    logic [OP_W-1:0]    rr_ptr_q;
    logic               cw_valid_q;
    logic [OP_W-1:0]    cw_opcode_q;
    logic               cw_enable_q;
    logic [NUM_OPS-1:0] gnt_q;
    logic               drop_err_q, drop_err_d;

    logic               found;
    logic [OP_W-1:0]    pick;
    logic               slot_free;
    logic               load;
    logic [NUM_OPS-1:0] pick_oh;
    logic [NUM_OPS-1:0] clear_vec;

    rr_pick u_rr_pick (
        .vec   (pend_q),
        .ptr   (rr_ptr_q),
        .found (found),
        .idx   (pick)
    );

    assign slot_free = (state_q == IDLE) || cw_ready;
    assign load      = slot_free && found;
    assign pick_oh   = NUM_OPS'(1) << pick;
    assign clear_vec = load ? pick_oh : '0;

    // A re-request landing on the bit being granted this cycle stays pending and is not a drop.
    assign pend_d     = (pend_q & ~clear_vec) | req_pulse;
    assign drop_err_d = (|(req_pulse & pend_q & ~clear_vec)) || (drop_err_q && !clr_err);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            cw_valid_q  <= 1'b0;
            cw_opcode_q <= '0;
            cw_enable_q <= 1'b0;
            gnt_q       <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            drop_err_q <= drop_err_d;
            gnt_q      <= '0;
            if (slot_free) begin
                if (found) begin
                    state_q     <= HOLD;
                    cw_valid_q  <= 1'b1;
                    cw_opcode_q <= pick;
                    cw_enable_q <= pim_mask[pick];
                    gnt_q       <= pick_oh;
                    rr_ptr_q    <= pick + OP_W'(1);
                end else begin
                    state_q    <= IDLE;
                    cw_valid_q <= 1'b0;
                end
            end
        end
    end

    assign cw_valid  = cw_valid_q;
    assign cw_opcode = cw_opcode_q;
    assign cw_enable = cw_enable_q;
    assign gnt       = gnt_q;
    assign pend_o    = pend_q;
    assign drop_err  = drop_err_q;
endmodule

// File: tb/tb_ucode_op_encoder.sv
// Directed bench for ucode_op_encoder with an in-order scoreboard of issued control words.
module tb_ucode_op_encoder;
    import ucode_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_OPS-1:0] req_pulse;
    logic [NUM_OPS-1:0] pim_mask;
    logic               cw_ready;
    logic               clr_err;
    logic               cw_valid;
    logic [OP_W-1:0]    cw_opcode;
    logic               cw_enable;
    logic [NUM_OPS-1:0] gnt;
    logic [NUM_OPS-1:0] pend_o;
    logic               drop_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            en;
    } word_t;
    word_t exp_q[$];

    ucode_op_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_pulse (req_pulse),
        .pim_mask  (pim_mask),
        .cw_ready  (cw_ready),
        .clr_err   (clr_err),
        .cw_valid  (cw_valid),
        .cw_opcode (cw_opcode),
        .cw_enable (cw_enable),
        .gnt       (gnt),
        .pend_o    (pend_o),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int op);
        word_t w;
        w.op = OP_W'(op);
        w.en = pim_mask[op];
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Every handshake must match the next expected word in issue order.
    always @(negedge clk) begin
        word_t w;
        if (rst_n === 1'b1 && cw_valid === 1'b1 && cw_ready === 1'b1) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed opcode 0x%0h expected no transfer", cw_opcode);
            end
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("sb_opcode", 32'(cw_opcode), 32'(w.op));
                chk("sb_enable", 32'(cw_enable), 32'(w.en));
                chk("sb_gnt_align", 32'(gnt == '0 || gnt == (NUM_OPS'(1) << cw_opcode)), 32'd1);
            end
        end
    end

    initial begin
        req_pulse = '0;
        pim_mask  = 16'hA5A5;
        cw_ready  = 1'b0;
        clr_err   = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid",  32'(cw_valid),  32'd0);
        chk("rst_opcode", 32'(cw_opcode), 32'd0);
        chk("rst_enable", 32'(cw_enable), 32'd0);
        chk("rst_gnt",    32'(gnt),       32'd0);
        chk("rst_pend",   32'(pend_o),    32'd0);
        chk("rst_drop",   32'(drop_err),  32'd0);

        // Single request, op 5 (PIM)
        cw_ready = 1'b1;
        req_pulse = 16'h0020; push(5);
        tick(); req_pulse = '0;
        chk("s_pend_n1",  32'(pend_o),   32'h0020);
        chk("s_valid_n1", 32'(cw_valid), 32'd0);
        tick();
        chk("s_valid_n2",  32'(cw_valid),  32'd1);
        chk("s_opcode_n2", 32'(cw_opcode), 32'd5);
        chk("s_enable_n2", 32'(cw_enable), 32'd1);
        chk("s_gnt_n2",    32'(gnt),       32'h0020);
        chk("s_pend_n2",   32'(pend_o),    32'h0000);
        tick();
        chk("s_valid_n3", 32'(cw_valid), 32'd0);
        chk("s_gnt_n3",   32'(gnt),      32'd0);

        // Multi-request order from rr_ptr=0
        do_reset();
        cw_ready = 1'b1;
        req_pulse = 16'h0208; push(3); push(9);
        tick(); req_pulse = '0;
        tick();
        chk("m_op3", 32'(cw_opcode), 32'd3);
        chk("m_gnt3", 32'(gnt), 32'h0008);
        tick();
        chk("m_op9", 32'(cw_opcode), 32'd9);
        chk("m_gnt9", 32'(gnt), 32'h0200);
        chk("m_valid9", 32'(cw_valid), 32'd1);
        tick();
        chk("m_idle", 32'(cw_valid), 32'd0);
        // rr_ptr=10 means op 10 beats op 0
        req_pulse = 16'h0401; push(10); push(0);
        tick(); req_pulse = '0;
        tick();
        chk("m_ptr10_first", 32'(cw_opcode), 32'd10);
        tick();
        chk("m_ptr10_second", 32'(cw_opcode), 32'd0);
        tick();

        // Backpressure: op 1 held 5 cycles; mask change must not affect the held word
        cw_ready = 1'b0;
        req_pulse = 16'h0002; push(1);
        tick(); req_pulse = '0;
        tick();
        chk("bp_valid_first",  32'(cw_valid),  32'd1);
        chk("bp_opcode_first", 32'(cw_opcode), 32'd1);
        chk("bp_gnt_first",    32'(gnt),       32'h0002);
        pim_mask = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("bp_valid_hold",  32'(cw_valid),  32'd1);
            chk("bp_opcode_hold", 32'(cw_opcode), 32'd1);
            chk("bp_enable_hold", 32'(cw_enable), 32'd0);
            chk("bp_gnt_hold",    32'(gnt),       32'd0);
        end
        cw_ready = 1'b1;
        tick();
        chk("bp_released", 32'(cw_valid), 32'd0);
        pim_mask = 16'hA5A5;

        // Wrap-around: rr_ptr 14 after op 13, then 15 before 2
        req_pulse = 16'h2000; push(13);
        tick(); req_pulse = '0;
        tick();
        chk("w_op13", 32'(cw_opcode), 32'd13);
        tick();
        req_pulse = 16'h8004; push(15); push(2);
        tick(); req_pulse = '0;
        chk("w_pend", 32'(pend_o), 32'h8004);
        tick();
        chk("w_op15", 32'(cw_opcode), 32'd15);
        chk("w_en15", 32'(cw_enable), 32'd1);
        tick();
        chk("w_op2", 32'(cw_opcode), 32'd2);
        tick();
        chk("w_idle", 32'(cw_valid), 32'd0);
        // rr_ptr=3: op 1 (wrapped) wins over op 2
        req_pulse = 16'h0006; push(1); push(2);
        tick(); req_pulse = '0;
        tick();
        chk("w_ptr3_first", 32'(cw_opcode), 32'd1);
        tick();
        chk("w_ptr3_second", 32'(cw_opcode), 32'd2);
        tick();

        // Duplicate request of op 7 while slot held by op 0
        cw_ready = 1'b0;
        req_pulse = 16'h0001; push(0);
        tick(); req_pulse = '0;
        tick();
        chk("d_hold_op0", 32'(cw_opcode), 32'd0);
        req_pulse = 16'h0080;
        tick();
        chk("d_no_err_yet", 32'(drop_err), 32'd0);
        tick(); req_pulse = '0;
        chk("d_err_set", 32'(drop_err), 32'd1);
        chk("d_pend7",   32'(pend_o),   32'h0080);
        cw_ready = 1'b1; push(7);
        tick();
        chk("d_op7", 32'(cw_opcode), 32'd7);
        tick();
        chk("d_once_valid", 32'(cw_valid), 32'd0);
        chk("d_once_pend",  32'(pend_o),   32'd0);
        chk("d_sticky",     32'(drop_err), 32'd1);
        clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        chk("d_cleared", 32'(drop_err), 32'd0);

        // Same-cycle re-request of the op being loaded issues twice, no error
        req_pulse = 16'h0100; push(8); push(8);
        tick();
        tick(); req_pulse = '0;
        chk("r_op8_a",  32'(cw_opcode), 32'd8);
        chk("r_gnt_a",  32'(gnt),       32'h0100);
        chk("r_pend",   32'(pend_o),    32'h0100);
        chk("r_no_err", 32'(drop_err),  32'd0);
        tick();
        chk("r_op8_b",  32'(cw_opcode), 32'd8);
        chk("r_gnt_b",  32'(gnt),       32'h0100);
        chk("r_valid_b", 32'(cw_valid), 32'd1);
        tick();
        chk("r_idle",    32'(cw_valid), 32'd0);
        chk("r_no_err2", 32'(drop_err), 32'd0);

        // Drop and clr_err in the same cycle: set wins
        cw_ready = 1'b0;
        req_pulse = 16'h0010; push(4);
        tick(); req_pulse = '0;
        tick();
        chk("c_hold_op4", 32'(cw_opcode), 32'd4);
        req_pulse = 16'h0010;
        tick();
        clr_err = 1'b1;
        tick(); req_pulse = '0; clr_err = 1'b0;
        chk("c_set_wins", 32'(drop_err), 32'd1);
        cw_ready = 1'b1; push(4);
        tick();
        chk("c_op4_again", 32'(cw_opcode), 32'd4);
        tick();
        chk("c_idle", 32'(cw_valid), 32'd0);
        clr_err = 1'b1;
        tick(); clr_err = 1'b0;

        // Reset mid-HOLD discards the held word and pend=0x00F0
        cw_ready = 1'b0;
        req_pulse = 16'h0008;
        tick();
        req_pulse = 16'h00F0;
        tick(); req_pulse = '0;
        chk("x_valid_pre", 32'(cw_valid), 32'd1);
        chk("x_pend_pre",  32'(pend_o),   32'h00F0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("x_valid",  32'(cw_valid),  32'd0);
        chk("x_opcode", 32'(cw_opcode), 32'd0);
        chk("x_enable", 32'(cw_enable), 32'd0);
        chk("x_gnt",    32'(gnt),       32'd0);
        chk("x_pend",   32'(pend_o),    32'd0);
        chk("x_drop",   32'(drop_err),  32'd0);
        cw_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("x_quiet_valid", 32'(cw_valid), 32'd0);
            chk("x_quiet_gnt",   32'(gnt),      32'd0);
        end

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
